// File: rtl/mem_stage_sbuf_if.sv
// Pipeline-side and data-memory-side signals of the memory-stage controller.
// The slave modport is the controller's view. The master modport is the environment's view.
interface mem_stage_sbuf_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WriteData;
    logic              halt;
    logic              halt_wb;
    logic [DATA_W-1:0] ReadData;
    logic              done;
    logic              stall_mem;
    logic              err;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              createdump;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              mem_stall;
    logic              mem_err;

    modport slave (
        input  MemRead, MemWrite, Addr, WriteData, halt, halt_wb,
        input  mem_rdata, mem_done, mem_stall, mem_err,
        output ReadData, done, stall_mem, err,
        output mem_rd, mem_wr, mem_addr, mem_wdata, createdump
    );

    modport master (
        output MemRead, MemWrite, Addr, WriteData, halt, halt_wb,
        output mem_rdata, mem_done, mem_stall, mem_err,
        input  ReadData, done, stall_mem, err,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, createdump
    );
endinterface

// File: rtl/mem_stage_sbuf.sv
// Memory-stage controller. A store buffer retires stores without stalling and forwards data to loads.
// The buffer drains to the multi-cycle data memory in the background, and is flushed before the halt dump.
module mem_stage_sbuf #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int SB_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    mem_stage_sbuf_if.slave  bus
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_DRAIN     = 3'd2;
    localparam logic [2:0] S_HALTDRAIN = 3'd3;
    localparam logic [2:0] S_DUMP      = 3'd4;
    localparam logic [2:0] S_DONE_H    = 3'd5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_ent_t;

    sb_ent_t           sb_q [SB_DEPTH];
    logic [PW-1:0]     head_q, tail_q, fwd_idx;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        state_q, state_d;
    logic              hd_busy_q, err_q;

    logic rd, wr, req, mis, hit, empty, full, accept;
    logic in_idle, in_drain, in_load, in_hd;
    logic pop, enq, fwd, load_done, done_c;
    logic issue_rd, issue_wr_idle, issue_wr_hd, issue_wr;
    logic [DATA_W-1:0] fwd_data;

    // A simultaneous read and write is handled as a write.
    assign wr  = bus.MemWrite & ~bus.halt_wb;
    assign rd  = bus.MemRead & ~bus.halt_wb & ~bus.MemWrite;
    assign req = rd | wr;
    assign mis = req & bus.Addr[0];

    assign in_idle  = state_q == S_IDLE;
    assign in_drain = state_q == S_DRAIN;
    assign in_load  = state_q == S_LOAD;
    assign in_hd    = state_q == S_HALTDRAIN;
    assign accept   = in_idle | in_drain;
    assign empty    = cnt_q == '0;
    assign full     = cnt_q == CW'(SB_DEPTH);

    // Scan from oldest to youngest, so the last match is the youngest matching entry.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if (CW'(i) < cnt_q && sb_q[fwd_idx].addr == bus.Addr) begin
                hit      = 1'b1;
                fwd_data = sb_q[fwd_idx].data;
            end
        end
    end

    assign pop       = (in_drain | (in_hd & hd_busy_q)) & bus.mem_done;
    assign enq       = accept & wr & ~mis & (~full | pop);
    assign fwd       = accept & rd & ~mis & hit;
    assign load_done = in_load & bus.mem_done;
    assign done_c    = (accept & mis) | enq | fwd | load_done;

    // An unforwarded load matches no buffered entry, so it may overtake pending drains.
    assign issue_rd      = in_idle & ~bus.halt & rd & ~mis & ~hit & ~bus.mem_stall;
    assign issue_wr_idle = in_idle & ~bus.halt & ~issue_rd & ~empty & ~bus.mem_stall;
    assign issue_wr_hd   = in_hd & ~hd_busy_q & ~empty & ~bus.mem_stall;
    assign issue_wr      = issue_wr_idle | issue_wr_hd;

    assign bus.done       = done_c;
    assign bus.ReadData   = load_done ? bus.mem_rdata : (fwd ? fwd_data : '0);
    assign bus.err        = (accept & mis) | (load_done & bus.mem_err) | err_q;
    // A halt that is still waiting to reach the halt-drain phase holds the pipeline frozen.
    assign bus.stall_mem  = (req & ~done_c) | (bus.halt & (in_idle | in_drain | in_load))
                          | in_hd | (state_q == S_DUMP);
    assign bus.mem_rd     = issue_rd;
    assign bus.mem_wr     = issue_wr;
    assign bus.mem_addr   = issue_rd ? bus.Addr : (issue_wr ? sb_q[head_q].addr : '0);
    assign bus.mem_wdata  = issue_wr ? sb_q[head_q].data : '0;
    assign bus.createdump = state_q == S_DUMP;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.halt)     state_d = empty ? S_DUMP : S_HALTDRAIN;
                else if (issue_rd) state_d = S_LOAD;
                else if (issue_wr) state_d = S_DRAIN;
            end
            S_LOAD:      if (bus.mem_done) state_d = S_IDLE;
            S_DRAIN:     if (bus.mem_done) state_d = S_IDLE;
            S_HALTDRAIN: if (~hd_busy_q && empty) state_d = S_DUMP;
            S_DUMP:      state_d = S_DONE_H;
            S_DONE_H:    state_d = S_DONE_H;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            hd_busy_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (enq) tail_q <= tail_q + 1'b1;
            if (pop) head_q <= head_q + 1'b1;
            cnt_q <= cnt_q + CW'(enq) - CW'(pop);
            if (issue_wr_hd)  hd_busy_q <= 1'b1;
            else if (pop)     hd_busy_q <= 1'b0;
            if (pop && bus.mem_err) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) sb_q[tail_q] <= '{addr: bus.Addr, data: bus.WriteData};
    end
endmodule
